// File: rtl/dm_pkg.sv
// Shared data-memory definitions: store/load mode codes, the load-unit
// state encoding and small helpers used by the load path.
package dm_pkg;

  // Store modes consumed by the byte-enable decoder
  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_W    = 3'd1;
  localparam logic [2:0] ST_H    = 3'd2;
  localparam logic [2:0] ST_B    = 3'd3;

  // Load modes; anything above LD_B behaves like LD_NONE
  localparam logic [3:0] LD_NONE = 4'd0;
  localparam logic [3:0] LD_W    = 4'd1;
  localparam logic [3:0] LD_HU   = 4'd2;
  localparam logic [3:0] LD_H    = 4'd3;
  localparam logic [3:0] LD_BU   = 4'd4;
  localparam logic [3:0] LD_B    = 4'd5;

  typedef enum logic [1:0] {
    DMLU_IDLE,
    DMLU_WAIT,
    DMLU_DONE,
    DMLU_ERR
  } dmlu_state_t;

  // True for the five modes that actually perform a load
  function automatic logic isLoadMode(input logic [3:0] mode);
    return (mode >= LD_W) && (mode <= LD_B);
  endfunction

  // Words need a zero offset, halfwords an even offset, bytes never fault
  function automatic logic isUnalignedLoad(input logic [3:0] mode, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (mode == LD_W)
      bad = (off != 2'b00);
    else if ((mode == LD_H) || (mode == LD_HU))
      bad = off[0];
    return bad;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Little-endian lane select plus zero/sign extension of a returned word.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [3:0]  i_Mode,
  input  logic [1:0]  i_Off,
  input  logic [31:0] i_Word,
  output logic [31:0] o_Data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it according to the load mode
  always_comb begin
    w_byte = i_Word[{i_Off, 3'b000} +: 8];
    w_half = i_Off[1] ? i_Word[31:16] : i_Word[15:0];
    case (i_Mode)
      LD_W:    o_Data = i_Word;
      LD_HU:   o_Data = {16'h0000, w_half};
      LD_H:    o_Data = {{16{w_half[15]}}, w_half};
      LD_BU:   o_Data = {24'h000000, w_byte};
      LD_B:    o_Data = {{24{w_byte[7]}}, w_byte};
      default: o_Data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// MEM-stage load unit: issues a word-aligned bus read, waits for a
// variable-latency acknowledge (with timeout) and returns the extended
// result, or flags AdEL / bus error for the exception logic.
module dm_load_unit
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DMLU_i_Req,
  input  logic [31:0] DMLU_i_Addr,
  input  logic [3:0]  DMLU_i_Mode,
  output logic        DMLU_o_Busy,
  output logic        DMLU_o_BusReq,
  output logic [31:0] DMLU_o_BusAddr,
  input  logic        DMLU_i_BusAck,
  input  logic [31:0] DMLU_i_BusRData,
  output logic        DMLU_o_Valid,
  output logic [31:0] DMLU_o_Data,
  output logic        DMLU_o_AdEL,
  output logic        DMLU_o_BusErr
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  dmlu_state_t r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_mode;
  logic [1:0]  r_off;
  logic        r_busReq;
  logic [31:0] r_busAddr;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_adel;
  logic        r_busErr;
  logic [31:0] w_ext;

  dm_load_ext u_ext (
    .i_Mode (r_mode),
    .i_Off  (r_off),
    .i_Word (DMLU_i_BusRData),
    .o_Data (w_ext)
  );

  // Load FSM; result pulses default low so each lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= DMLU_IDLE;
      r_cnt     <= 8'd0;
      r_mode    <= LD_NONE;
      r_off     <= 2'b00;
      r_busReq  <= 1'b0;
      r_busAddr <= 32'h0000_0000;
      r_valid   <= 1'b0;
      r_data    <= 32'h0000_0000;
      r_adel    <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_data   <= 32'h0000_0000;
      r_adel   <= 1'b0;
      r_busErr <= 1'b0;
      case (r_state)
        DMLU_IDLE: begin
          if (DMLU_i_Req && isLoadMode(DMLU_i_Mode)) begin
            r_mode    <= DMLU_i_Mode;
            r_off     <= DMLU_i_Addr[1:0];
            r_busAddr <= {DMLU_i_Addr[31:2], 2'b00};
            if (isUnalignedLoad(DMLU_i_Mode, DMLU_i_Addr[1:0])) begin
              r_state <= DMLU_ERR;
              r_adel  <= 1'b1;
            end else begin
              r_state  <= DMLU_WAIT;
              r_busReq <= 1'b1;
              r_cnt    <= 8'd0;
            end
          end
        end
        DMLU_WAIT: begin
          if (DMLU_i_BusAck) begin
            r_state  <= DMLU_DONE;
            r_busReq <= 1'b0;
            r_valid  <= 1'b1;
            r_data   <= w_ext;
          end else if (r_cnt == CntLast) begin
            r_state  <= DMLU_DONE;
            r_busReq <= 1'b0;
            r_busErr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DMLU_DONE: r_state <= DMLU_IDLE;
        DMLU_ERR:  r_state <= DMLU_IDLE;
        default:   r_state <= DMLU_IDLE;
      endcase
    end
  end

  assign DMLU_o_Busy    = (r_state != DMLU_IDLE);
  assign DMLU_o_BusReq  = r_busReq;
  assign DMLU_o_BusAddr = r_busAddr;
  assign DMLU_o_Valid   = r_valid;
  assign DMLU_o_Data    = r_data;
  assign DMLU_o_AdEL    = r_adel;
  assign DMLU_o_BusErr  = r_busErr;

endmodule
